mdc_commutator: RTL
===================

Name: mdc_commutator

Overview:
- Data-exchange stage between two radix-2 butterfly columns of the pipelined MDC FFT.
- Takes two parallel streams (upper a, lower b) and uses delay, switch and delay to re-pair samples that lie D apart.
- Delay elements are shift registers advanced only by accepted samples, so the block tolerates gaps in the stream.
- Output is registered.

Parameters:
- nb, 16, sample width in bits (complex word width shared with the rest of the FFT datapath).
- D, 4, commutator distance in samples; power of two, D >= 1.
- LD, log2(D), counter width helper; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_a/in_b carry a sample this cycle (step n advances).
- in_a  input  nb  upper input stream sample a_n.
- in_b  input  nb  lower input stream sample b_n.
- out_valid  output  1  out_a/out_b/out_phase valid this cycle.
- out_a  output  nb  upper output sample.
- out_b  output  nb  lower output sample.
- out_phase  output  1  1 = pair drawn from b stream, 0 = pair drawn from a stream.

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out_valid=0, out_a=0, out_b=0, out_phase=0; step counter=0; fill flag=0.
- Delay line contents are not reset; they are masked by the fill flag.
- Step counter n: LD+1 bits, increments once per in_valid cycle, wraps modulo 2D.
- Switch select s = bit LD of n; for D=1, s = n[0].
- Per accepted step n:
  - DL1 = D-deep enabled shift of in_a, giving ad_n = a_{n-D}.
  - Switch, s=0: x = ad_n, y = in_b.
  - Switch, s=1: x = in_b, y = ad_n.
  - DL2 = D-deep enabled shift of y.
  - out_a <= x; out_b <= DL2 output (y_{n-D}); out_phase <= s.
- Resulting output pairs:
  - s=1 steps: (b_n, b_{n-D}).
  - s=0 steps at n >= 2D: (a_{n-D}, a_{n-2D}).
- Latency: outputs update on the clock edge that accepts step n and are visible the following cycle.
- out_valid:
  - Registered copy of (in_valid AND fill).
  - fill sets once D steps have been accepted since reset, i.e. the first valid output is step n=D; fill then stays set.
- in_valid=0:
  - No shift, counter holds, out_valid=0.
  - out_a/out_b/out_phase hold their last values.
- Gaps of any length have no effect on the pairing (all delays are step-based, not cycle-based).
- Counter wrap at 2D-1 -> 0 is seamless; fill stays set.
- Reset mid-stream: next cycle out_valid=0, counter=0, fill=0; the following D accepted steps are treated as fill, and stale delay data is never marked valid.
- rst and in_valid in the same cycle: reset wins and the sample is dropped.
- No backpressure; downstream must accept every out_valid cycle.

Test Plan:
- Continuous run, D=2, a_n=n, b_n=100+n, in_valid always 1 from step 0:
  - out_valid first high for step 2.
  - Pairs (out_a,out_b,out_phase) for steps 2..7: (102,100,1) (103,101,1) (2,0,0) (3,1,0) (106,104,1) (107,105,1).
- Same stream with in_valid toggling 1,0,1,0: identical pair sequence.
  - out_valid high only the cycle after each accepted step.
  - Outputs hold during gaps.
- D=1, a_n=n, b_n=100+n:
  - Step 1 -> (101,100,1); step 2 -> (1,0,0); step 3 -> (103,102,1).
- Reset after step 5 (D=2), then restart a_n=50+n, b_n=150+n:
  - No out_valid for restarted steps 0,1.
  - Step 2 -> (152,150,1).
  - No pre-reset data ever appears with out_valid=1.
- rst and in_valid both high in one cycle: sample dropped, counter=0, out_valid=0 next cycle.
- D=4, random data, 1000 steps with random in_valid: a scoreboard computing the pair formulas matches every out_valid cycle.

Source files
------------

// File: rtl/mdc_commutator.sv
// Data-exchange stage between two radix-2 butterfly columns of a pipelined MDC FFT.
// Re-pairs samples that are D steps apart using the delay / switch / delay structure.
module mdc_commutator #(
    parameter int nb = 16,
    parameter int D  = 4,
    localparam int LD = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [nb-1:0] in_a,
    input  logic [nb-1:0] in_b,
    output logic          out_valid,
    output logic [nb-1:0] out_a,
    output logic [nb-1:0] out_b,
    output logic          out_phase
);

    localparam logic [LD:0] FILL_LAST = (LD+1)'(D - 1);

    logic [LD:0]   cnt;
    logic          fill;
    logic          accept;
    logic          sel;
    logic [nb-1:0] ad;
    logic [nb-1:0] x;
    logic [nb-1:0] y;
    logic [nb-1:0] dl1 [D];
    logic [nb-1:0] dl2 [D];

    // A sample arriving together with reset is dropped, so nothing moves that cycle.
    assign accept = in_valid & ~rst;
    assign sel    = cnt[LD];
    assign ad     = dl1[D-1];

    always_comb begin
        x = ad;
        y = in_b;
        if (sel) begin
            x = in_b;
            y = ad;
        end
    end

    // Delay lines advance per accepted step, not per cycle; contents are masked by fill.
    always_ff @(posedge clk) begin
        if (accept) begin
            dl1[0] <= in_a;
            dl2[0] <= y;
            for (int i = 1; i < D; i++) begin
                dl1[i] <= dl1[i-1];
                dl2[i] <= dl2[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            fill      <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_phase <= 1'b0;
        end else begin
            out_valid <= in_valid & fill;
            if (in_valid) begin
                cnt       <= cnt + 1'b1;
                out_a     <= x;
                out_b     <= dl2[D-1];
                out_phase <= sel;
                if (cnt == FILL_LAST)
                    fill <= 1'b1;
            end
        end
    end

endmodule
